// File: rtl/cache_nway_if.sv
// Core-side request/response and backing-memory handshake bundle for cache_nway.
// The cache sits on the slave modport; the requester/memory model sits on master.
interface cache_nway_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              resp_valid;
    logic [DATA_W-1:0] q;
    logic              hit;
    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, wr, addr, data, mem_ack, mem_rdata,
        output req_ready, resp_valid, q, hit, mem_req, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, wr, addr, data, mem_ack, mem_rdata,
        input  req_ready, resp_valid, q, hit, mem_req, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_nway.sv
// N-way set-associative write-through, read-allocate cache with true-LRU; read hit 2 cycles, else 2 + memory wait.
// One request in flight: req_ready only in IDLE; mem_req held until mem_ack.
module cache_nway #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int SETS   = 8,
    parameter int WAYS   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    cache_nway_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int AGE_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              lkhit_q, lkhit_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              hit_q, hit_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              vld_q [SETS][WAYS];
    logic              vld_d [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_d [SETS][WAYS];
    logic [DATA_W-1:0] dat_q [SETS][WAYS];
    logic [DATA_W-1:0] dat_d [SETS][WAYS];
    logic [AGE_W-1:0]  age_q [SETS][WAYS];
    logic [AGE_W-1:0]  age_d [SETS][WAYS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit_any, inv_any, pr_en;
    logic [AGE_W-1:0]  hit_way, inv_way, lru_way, victim, pr_way;

    assign idx = addr_q[IDX_W-1:0];
    assign tag = addr_q[ADDR_W-1:IDX_W];

    // Scan downwards so the lowest-index invalid way wins the victim choice.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit_any = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!vld_q[idx][w]) begin
                inv_any = 1'b1;
                inv_way = AGE_W'(w);
            end
            if (age_q[idx][w] == AGE_W'(WAYS - 1)) begin
                lru_way = AGE_W'(w);
            end
        end
    end

    assign victim = inv_any ? inv_way : lru_way;

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        lkhit_d     = lkhit_q;
        q_d         = q_q;
        hit_d       = hit_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        vld_d       = vld_q;
        tag_d       = tag_q;
        dat_d       = dat_q;
        age_d       = age_q;
        pr_en       = 1'b0;
        pr_way      = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.wr;
                    addr_d  = bus.addr;
                    wdat_d  = bus.data;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                lkhit_d = hit_any;
                if (!wr_q && hit_any) begin
                    q_d     = dat_q[idx][hit_way];
                    hit_d   = 1'b1;
                    pr_en   = 1'b1;
                    pr_way  = hit_way;
                    state_d = RESP;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_wr_d   = wr_q;
                    mem_addr_d = addr_q;
                    if (wr_q) begin
                        mem_wdata_d = wdat_q;
                        state_d     = MEM_WR;
                        if (hit_any) begin
                            dat_d[idx][hit_way] = wdat_q;
                            pr_en  = 1'b1;
                            pr_way = hit_way;
                        end
                    end else begin
                        state_d = MEM_RD;
                    end
                end
            end
            MEM_RD: begin
                if (bus.mem_ack) begin
                    vld_d[idx][victim] = 1'b1;
                    tag_d[idx][victim] = tag;
                    dat_d[idx][victim] = bus.mem_rdata;
                    pr_en     = 1'b1;
                    pr_way    = victim;
                    q_d       = bus.mem_rdata;
                    hit_d     = 1'b0;
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            MEM_WR: begin
                if (bus.mem_ack) begin
                    hit_d     = lkhit_q;
                    mem_req_d = 1'b0;
                    mem_wr_d  = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Ages younger than the promoted way slide back by one; the promoted way becomes MRU.
        if (pr_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] < age_q[idx][pr_way]) begin
                    age_d[idx][w] = age_q[idx][w] + AGE_W'(1);
                end
            end
            age_d[idx][pr_way] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdat_q      <= '0;
            lkhit_q     <= 1'b0;
            q_q         <= '0;
            hit_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    vld_q[s][w] <= 1'b0;
                    tag_q[s][w] <= '0;
                    dat_q[s][w] <= '0;
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            lkhit_q     <= lkhit_d;
            q_q         <= q_d;
            hit_q       <= hit_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            vld_q       <= vld_d;
            tag_q       <= tag_d;
            dat_q       <= dat_d;
            age_q       <= age_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.q          = q_q;
    assign bus.hit        = hit_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: doc/cache_nway.md
Name: cache_nway

Overview:
- Parametrised N-way set-associative, write-through, read-allocate cache. It is the successor to cache_2way.
- Sits between a core-side word request port and a slower backing memory reached over a req/ack handshake.
- Adds configurable width, sets and ways, true-LRU replacement, valid bits, hit reporting, backpressure and asynchronous reset.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 32, word address width (one word per line)
SETS, 8, number of sets; power of 2, at least 2; IDX_W = log2(SETS)
WAYS, 2, associativity; power of 2, at least 2; AGE_W = log2(WAYS)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core request present
req_ready  output  1  cache can accept a request (state IDLE)
wr  input  1  1 = write, 0 = read; sampled with the request
addr  input  ADDR_W  word address
data  input  DATA_W  write data
resp_valid  output  1  one-cycle completion pulse
q  output  DATA_W  read data; valid when resp_valid is high
hit  output  1  request hit in the cache; valid when resp_valid is high
mem_req  output  1  backing-memory request; held high until mem_ack
mem_wr  output  1  1 = memory write
mem_addr  output  ADDR_W  memory word address
mem_wdata  output  DATA_W  memory write data
mem_ack  input  1  memory completion; one cycle; mem_rdata valid for reads
mem_rdata  input  DATA_W  memory read data

Behaviour:
- Address split: index = addr[IDX_W-1:0]; tag = addr[ADDR_W-1:IDX_W].
- Per way per set: valid bit, tag, data word, AGE_W-bit age. Age 0 = MRU, WAYS-1 = LRU.
- Reset (async, while rst_n=0):
  - state = IDLE; all valid bits cleared; age of way w = w in every set.
  - Outputs: req_ready=1; resp_valid, hit, mem_req, mem_wr = 0; q, mem_addr, mem_wdata = 0.
  - Any in-flight request is dropped with no response. A mem_ack arriving after reset release is ignored.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register wr, addr and data, then go to LOOKUP.
- LOOKUP:
  - Compare the registered tag against all valid ways of the set.
  - More than one matching way cannot occur and is not handled.
  - Read hit: q = hit way data; hit=1; promote the way; go to RESP.
  - Read miss: mem_req=1, mem_wr=0, mem_addr=addr; go to MEM_RD.
  - Write, hit or miss: mem_req=1, mem_wr=1, mem_addr=addr, mem_wdata=data; go to MEM_WR.
  - Write hit also updates the way data and promotes the way in this cycle.
- MEM_RD:
  - Hold mem_req and mem_addr stable until mem_ack.
  - On mem_ack: choose the victim (lowest-index invalid way, else the way with age WAYS-1).
  - Write the victim's tag and data, set it valid, promote it; q = mem_rdata; hit=0; go to RESP.
- MEM_WR:
  - Hold outputs until mem_ack.
  - On mem_ack: hit = the lookup result; q unchanged; go to RESP.
  - A write miss does not allocate.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Promote way p: every way in the set with age < age(p) increments; age(p) becomes 0. Ages stay a permutation of 0..WAYS-1.
- Latency from acceptance edge to resp_valid:
  - Read hit: 2 cycles.
  - Miss or any write: 2 cycles + cycles until mem_ack.
- mem_req drops in the cycle after mem_ack.
- mem_ack while mem_req=0 is ignored.
- Back-to-back requests: the next request is accepted in the cycle after RESP. There is no overlap, and req_ready=0 outside IDLE.

Test Plan:
1. Reset, then read addr 0x0 with memory returning 0x1 after 3 cycles -> mem_req with mem_addr=0x0; resp_valid with q=0x1, hit=0. Repeat the read -> hit=1, q=0x1, latency 2, no mem_req.
2. Write data 0x01 to addr 0x0 after a prior fill -> mem_wr=1, mem_wdata=0x01; resp_valid with hit=1. Read 0x0 -> q=0x01, hit=1. Write to unfilled addr 0x5 -> hit=0; a following read of 0x5 misses.
3. WAYS=2, SETS=8: read 0x00, 0x08, then 0x00, then 0x10 -> 0x10 evicts 0x08, the LRU way. Read 0x00 -> hit; read 0x08 -> miss.
4. WAYS=4: fill 4 tags in set 3, touch them in order 0,2,1,3 -> next miss evicts the way touched first. Check ages remain a permutation after every access.
5. Pulse rst_n low during MEM_RD -> mem_req and resp_valid go 0 immediately. Late mem_ack is ignored. A read of the same address afterwards misses.
6. Hold req_valid high continuously with mem_ack delay 0..5 -> exactly one resp_valid per accepted request; req_ready low from LOOKUP through RESP.
